// File: rtl/tdm_nibble_if.sv
// Bus bundle between a nibble TDM stream source and the demux that rebuilds
// the four parallel slot values.
interface tdm_nibble_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic             out_valid;
    logic             frame_err;
    logic [1:0]       slot;

    modport master (
        output in_valid, in_sof, in_data,
        input  out1, out2, out3, out4, out_valid, frame_err, slot
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out1, out2, out3, out4, out_valid, frame_err, slot
    );
endinterface

// File: rtl/tdm_nibble_demux.sv
// 1:4 TDM nibble demultiplexer: gathers a 4-slot frame into a shadow buffer and
// commits all slots to the outputs at once when the slot-3 beat arrives.
//
// state   | meaning
// IDLE    | waiting for an SOF beat (slot 0)
// COLLECT | slot 0 taken, gathering slots 1..3 with idle-gap timeout
module tdm_nibble_demux #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst_n,
    tdm_nibble_if.slave bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] shadow0, shadow1, shadow2;
    logic             shadow_we;
    logic [1:0]       wr_idx;
    logic             commit;
    logic             err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        slot_d    = slot_q;
        cnt_d     = cnt;
        shadow_we = 1'b0;
        wr_idx    = 2'd0;
        commit    = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_sof) begin
                        shadow_we = 1'b1;
                        slot_d    = 2'd1;
                        cnt_d     = '0;
                        state_d   = COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    cnt_d = '0;
                    if (bus.in_sof) begin
                        // early SOF restarts the frame with this beat as slot 0
                        err_d     = 1'b1;
                        shadow_we = 1'b1;
                        slot_d    = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        commit  = 1'b1;
                        slot_d  = 2'd0;
                        state_d = IDLE;
                    end else begin
                        shadow_we = 1'b1;
                        wr_idx    = slot_q;
                        slot_d    = slot_q + 2'd1;
                    end
                end else if (cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    slot_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= 2'd0;
            cnt           <= '0;
            shadow0       <= '0;
            shadow1       <= '0;
            shadow2       <= '0;
            bus.out1      <= '0;
            bus.out2      <= '0;
            bus.out3      <= '0;
            bus.out4      <= '0;
            bus.out_valid <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            cnt           <= cnt_d;
            bus.out_valid <= commit;
            bus.frame_err <= err_d;
            if (shadow_we) begin
                case (wr_idx)
                    2'd0:    shadow0 <= bus.in_data;
                    2'd1:    shadow1 <= bus.in_data;
                    default: shadow2 <= bus.in_data;
                endcase
            end
            if (commit) begin
                bus.out1 <= shadow0;
                bus.out2 <= shadow1;
                bus.out3 <= shadow2;
                bus.out4 <= bus.in_data;
            end
        end
    end

    assign bus.slot = slot_q;
endmodule

// File: tb/tb_tdm_nibble_demux.sv
// Randomized scoreboard bench for tdm_nibble_demux: a queue-based frame model
// predicts commits and error pulses, an independent monitor checks the outputs.
module tb_tdm_nibble_demux;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    tdm_nibble_if #(.WIDTH(WIDTH)) bus ();

    tdm_nibble_demux #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [3:0]  partial[$];
    int          gap      = 0;
    logic [1:0]  exp_slot = 2'd0;
    logic [15:0] last_out = 16'h0;
    int          n_commits = 0;
    int          n_errs    = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level reference: a frame is whatever beats have been gathered since SOF.
    task automatic model(bit v, bit s, logic [3:0] d);
        exp_t e;
        if (v && s) begin
            if (partial.size() > 0) begin
                e.err = 1'b1; e.data = '0; exp_q.push_back(e);
            end
            partial.delete();
            partial.push_back(d);
            gap = 0;
        end else if (v) begin
            if (partial.size() == 0) begin
                e.err = 1'b1; e.data = '0; exp_q.push_back(e);
            end else begin
                partial.push_back(d);
                gap = 0;
                if (partial.size() == 4) begin
                    e.err  = 1'b0;
                    e.data = {partial[0], partial[1], partial[2], partial[3]};
                    exp_q.push_back(e);
                    partial.delete();
                end
            end
        end else if (partial.size() > 0) begin
            gap++;
            if (gap >= TIMEOUT) begin
                e.err = 1'b1; e.data = '0; exp_q.push_back(e);
                partial.delete();
            end
        end
        exp_slot = 2'(partial.size());
    endtask

    task automatic step(bit v, bit s, logic [3:0] d);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        @(posedge clk);
        model(v, s, d);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 4'h0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic frame(logic [15:0] f, int g);
        step(1'b1, 1'b1, f[15:12]); idle(g);
        step(1'b1, 1'b0, f[11:8]);  idle(g);
        step(1'b1, 1'b0, f[7:4]);   idle(g);
        step(1'b1, 1'b0, f[3:0]);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_outs"}, {16'h0, bus.out1, bus.out2, bus.out3, bus.out4}, 32'h0);
        check({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h0);
        check({tag, "_err"}, {31'h0, bus.frame_err}, 32'h0);
        check({tag, "_slot"}, {30'h0, bus.slot}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            logic ev;
            ev = bus.out_valid | bus.frame_err;
            if (bus.out_valid && bus.frame_err) begin
                checks++; failures++;
                $display("FAIL pulse_overlap actual=11 required=not_both at %0t", $time);
            end
            check("event_presence", {31'h0, ev}, {31'h0, (exp_q.size() > 0)});
            if (ev && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("event_kind", {31'h0, bus.frame_err}, {31'h0, e.err});
                if (!e.err) begin
                    last_out = e.data;
                    n_commits++;
                end else begin
                    n_errs++;
                end
            end
            check("outs", {16'h0, bus.out1, bus.out2, bus.out3, bus.out4}, {16'h0, last_out});
            check("slot", {30'h0, bus.slot}, {30'h0, exp_slot});
        end
    end

    initial begin
        logic [3:0] d;
        int r;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // T2 normal frame, T3 gapped frame
        frame(16'hA5C3, 0);
        idle(3);
        frame(16'h1E7B, 2);
        idle(2);

        // T1 reset mid-frame
        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b0, 4'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        partial.delete();
        exp_q.delete();
        gap      = 0;
        exp_slot = 2'd0;
        last_out = 16'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // T4 early SOF
        frame(16'h4D2F, 0);
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        frame(16'h789A, 0);
        idle(2);

        // T5 timeout boundary: gap of TIMEOUT-1 survives, gap of TIMEOUT aborts
        step(1'b1, 1'b1, 4'h3); idle(TIMEOUT - 1);
        step(1'b1, 1'b0, 4'h4); step(1'b1, 1'b0, 4'h5); step(1'b1, 1'b0, 4'h6);
        idle(1);
        step(1'b1, 1'b1, 4'hF); idle(TIMEOUT);
        idle(2);
        step(1'b1, 1'b0, 4'h8);
        idle(2);

        // T6 back-to-back frames
        frame(16'h1234, 0);
        frame(16'hFEDC, 0);
        idle(2);

        // Randomized traffic with occasional long gaps around the timeout
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            d = 4'($urandom);
            if (r < 4) begin
                idle($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
            end else if (r < 30) begin
                step(1'b0, 1'b0, 4'h0);
            end else if (r < 42) begin
                step(1'b1, 1'b1, d);
            end else if (r < 50) begin
                frame({d, 12'($urandom)}, 0);
            end else begin
                step(1'b1, 1'b0, d);
            end
        end
        idle(TIMEOUT + 4);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        checks++;
        if (n_commits < 10 || n_errs < 10) begin
            failures++;
            $display("FAIL coverage commits=%0d errs=%0d required>=10 each", n_commits, n_errs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
